alu_matrix_engine: RTL and testbench
====================================

ALU_MATRIX_ENGINE -- requirements
Module: alu_matrix_engine

Interface
REQ-001 Parameter ELEM_W, default 8, signed two's-complement element width in bits (4..16).
REQ-002 Parameter MAX_N, default 5, largest supported matrix dimension (2..8).
REQ-003 Derived FLAT_W = MAX_N*MAX_N*ELEM_W; element (i,j) occupies bits [(i*MAX_N+j)*ELEM_W +: ELEM_W].
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  rising-edge system clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request; accepted only in IDLE.
REQ-008 opcode  input  3  001 sum, 010 sub, 011 mul, 100 opposite, 101 transpose, 110 scalar.
REQ-009 matrix_size  input  4  active dimension N, legal 1..MAX_N.
REQ-010 A_flat, B_flat  input  FLAT_W  operand matrices.
REQ-011 scalar  input  ELEM_W  signed scalar for opcode 110.
REQ-012 C_flat  output  FLAT_W  result matrix, registered.
REQ-013 busy  output  1  high while state is not IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 overflow_flag  output  1  any element overflowed in the last operation.
REQ-016 error_flag  output  1  last request was illegal.

Function
REQ-017 States: IDLE, RUN, DONE; IDLE->RUN on accepted start, RUN->DONE after final element, DONE->IDLE unconditionally.
REQ-018 On accept: capture opcode, N, A_flat, B_flat, scalar into internal registers; clear C_flat, overflow_flag, error_flag; later input changes have no effect.
REQ-019 start while busy is ignored, with no state or output change.
REQ-020 Element-wise ops (sum, sub, opposite, transpose, scalar) write one element per cycle in row-major order (i outer, j inner); RUN lasts N*N cycles.
REQ-021 Mul uses one MAC per cycle, with k innermost; it writes C(i,j) at k=N-1; RUN lasts N*N*N cycles.
REQ-022 Accepting start in cycle 0 gives done=1 in cycle N*N+1 (element-wise) or N*N*N+1 (mul); busy is high in cycles 1 through that cycle.
REQ-023 Transpose: C(i,j)=A(j,i); opposite: C=-A; scalar: C(i,j)=A(i,j)*scalar.
REQ-024 The mul accumulator is 2*ELEM_W+3 bits; overflow is evaluated only on the final accumulated value.
REQ-025 Overflow: full-precision result outside [-2^(ELEM_W-1), 2^(ELEM_W-1)-1]; this includes negating the minimum value; overflow_flag is sticky until the next accept.
REQ-026 Elements with i>=N or j>=N are zero in C_flat.
REQ-027 Illegal request (opcode 000/111, N=0, N>MAX_N): skip RUN, go directly to DONE; done in cycle 1; error_flag=1; C_flat all zero.
REQ-028 C_flat, overflow_flag and error_flag hold their values from DONE until the next accept.

Reset
REQ-029 reset_n low, at any time including mid-operation: state IDLE; C_flat, busy, done, overflow_flag, error_flag and all counters and accumulators 0.
REQ-030 The first start is accepted on the first rising edge at which reset_n is high.

Configuration
REQ-031 With ALU_MATRIX_SATURATE_EN defined: overflowing elements clamp to max/min signed value; overflow_flag is still set.
REQ-032 Without ALU_MATRIX_SATURATE_EN: overflowing elements wrap (low ELEM_W bits kept).

Structure
REQ-033 Package alu_matrix_pkg holds the opcode constants, the state enum typedef and the accumulator-width function.
REQ-034 Sub-module alu_mac_unit (multiply, accumulate, range check, saturate/wrap) is shared by the mul and scalar ops.

Verification
REQ-035 ELEM_W=8, N=2, sum A=[1,2;3,4], B=[10,20,30,40] -> C=[11,22;33,44], overflow 0, done in cycle 5.
REQ-036 N=3 mul, A=identity, B=[1..9] -> C=B, done in cycle 28; all elements outside 3x3 are 0.
REQ-037 N=1 sum, 100+100 -> overflow 1; C=-56 without the macro, 127 with the macro.
REQ-038 Opposite of A(0,0)=-128 -> overflow 1; transpose of [1,2;3,4] -> [1,3;2,4].
REQ-039 opcode 111 or N=6 with MAX_N=5 -> error 1, done in cycle 1, C=0.
REQ-040 reset_n pulsed low mid-mul -> all outputs 0 and IDLE; a start pulse in RUN is ignored and the result is unchanged.

Source files
------------

// File: rtl/alu_matrix_pkg.sv
// alu_matrix_pkg: opcodes, FSM state type and accumulator sizing shared by the matrix engine.
package alu_matrix_pkg;
  localparam logic [2:0] OP_SUM = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_OPP = 3'b100;
  localparam logic [2:0] OP_TRN = 3'b101;
  localparam logic [2:0] OP_SCL = 3'b110;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  function automatic int acc_w(input int elem_w);
    return 2 * elem_w + 3;
  endfunction
endpackage

// File: rtl/alu_mac_unit.sv
// alu_mac_unit: o_acc = i_acc + i_a*i_b with signed range check; result wraps, or clamps when ALU_MATRIX_SATURATE_EN is defined.
module alu_mac_unit import alu_matrix_pkg::*; #(
  parameter int ELEM_W = 8,
  parameter int ACC_W  = acc_w(ELEM_W)
) (
  input  logic signed [ELEM_W-1:0] i_a,
  input  logic signed [ELEM_W-1:0] i_b,
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [ACC_W-1:0]  o_acc,
  output logic signed [ELEM_W-1:0] o_res,
  output logic                     o_ovf
);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (ELEM_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;
  logic signed [ACC_W-1:0] w_a, w_b;
  assign w_a = {{(ACC_W-ELEM_W){i_a[ELEM_W-1]}}, i_a};
  assign w_b = {{(ACC_W-ELEM_W){i_b[ELEM_W-1]}}, i_b};
  assign o_acc = i_acc + w_a * w_b;
  assign o_ovf = o_acc > MAX_V || o_acc < MIN_V;
`ifdef ALU_MATRIX_SATURATE_EN
  assign o_res = o_ovf ? (o_acc[ACC_W-1] ? MIN_V[ELEM_W-1:0] : MAX_V[ELEM_W-1:0]) : o_acc[ELEM_W-1:0];
`else
  assign o_res = o_acc[ELEM_W-1:0];
`endif
endmodule

// File: rtl/alu_matrix_engine.sv
// alu_matrix_engine: sequential matrix ALU (sum/sub/mul/opposite/transpose/scalar), one MAC step per cycle.
// Optional ALU_MATRIX_SATURATE_EN clamps overflowing elements instead of wrapping.
module alu_matrix_engine import alu_matrix_pkg::*; #(
  parameter  int ELEM_W = 8,
  parameter  int MAX_N  = 5,
  localparam int FLAT_W = MAX_N * MAX_N * ELEM_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [2:0]               opcode,
  input  logic [3:0]               matrix_size,
  input  logic [FLAT_W-1:0]        A_flat,
  input  logic [FLAT_W-1:0]        B_flat,
  input  logic signed [ELEM_W-1:0] scalar,
  output logic [FLAT_W-1:0]        C_flat,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow_flag,
  output logic                     error_flag
);
  localparam int ACC_W = acc_w(ELEM_W);
  state_t                   r_state;
  logic [2:0]               r_op;
  logic [3:0]               r_n, r_i, r_j, r_k;
  logic [FLAT_W-1:0]        r_a, r_b, r_c;
  logic signed [ELEM_W-1:0] r_s;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_ovf, r_err, r_done;
  logic                     w_legal, w_mul, w_addsub, w_wr, w_last_j, w_ovf;
  logic signed [ELEM_W-1:0] w_aij, w_ma, w_mb, w_res;
  logic signed [ACC_W-1:0]  w_macc, w_acc;
  int                       w_idx;
  function automatic logic [ELEM_W-1:0] el(input logic [FLAT_W-1:0] m, input logic [3:0] r, input logic [3:0] c);
    return m[(int'(r) * MAX_N + int'(c)) * ELEM_W +: ELEM_W];
  endfunction
  // Every op is mapped onto the single MAC: add/sub use A as the accumulator seed and B*(+/-1).
  always_comb begin
    w_mul    = r_op == OP_MUL;
    w_addsub = r_op == OP_SUM || r_op == OP_SUB;
    w_aij    = el(r_a, r_i, r_j);
    w_ma     = w_mul ? el(r_a, r_i, r_k) : w_addsub ? el(r_b, r_i, r_j) : r_op == OP_TRN ? el(r_a, r_j, r_i) : w_aij;
    w_mb     = w_mul ? el(r_b, r_k, r_j) : r_op == OP_SCL ? r_s : (r_op == OP_SUB || r_op == OP_OPP) ? '1 : ELEM_W'(1);
    w_macc   = w_mul ? r_acc : w_addsub ? {{(ACC_W-ELEM_W){w_aij[ELEM_W-1]}}, w_aij} : '0;
    w_wr     = !w_mul || r_k == r_n - 4'd1;
    w_last_j = r_j == r_n - 4'd1;
    w_idx    = (int'(r_i) * MAX_N + int'(r_j)) * ELEM_W;
    w_legal  = opcode != 3'b000 && opcode != 3'b111 && matrix_size != 4'd0 && 32'(matrix_size) <= MAX_N;
  end
  alu_mac_unit #(.ELEM_W(ELEM_W), .ACC_W(ACC_W)) u_mac (
    .i_a(w_ma), .i_b(w_mb), .i_acc(w_macc), .o_acc(w_acc), .o_res(w_res), .o_ovf(w_ovf)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_n     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_s     <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_op    <= opcode;
          r_n     <= matrix_size;
          r_a     <= A_flat;
          r_b     <= B_flat;
          r_s     <= scalar;
          r_c     <= '0;
          r_ovf   <= 1'b0;
          r_err   <= !w_legal;
          r_done  <= !w_legal;
          r_i     <= '0;
          r_j     <= '0;
          r_k     <= '0;
          r_acc   <= '0;
          r_state <= w_legal ? S_RUN : S_DONE;
        end
        S_RUN: begin
          r_acc <= w_wr ? '0 : w_acc;
          r_k   <= w_wr ? '0 : r_k + 4'd1;
          if (w_wr) begin
            r_c[w_idx +: ELEM_W] <= w_res;
            r_ovf <= r_ovf | w_ovf;
            r_j   <= w_last_j ? '0 : r_j + 4'd1;
            r_i   <= w_last_j ? r_i + 4'd1 : r_i;
          end
          if (w_wr && w_last_j && r_i == r_n - 4'd1) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign C_flat        = r_c;
  assign busy          = r_state != S_IDLE;
  assign done          = r_done;
  assign overflow_flag = r_ovf;
  assign error_flag    = r_err;
endmodule

// File: tb/tb_alu_matrix_engine.sv
// tb_alu_matrix_engine: directed self-checking bench for alu_matrix_engine (ELEM_W=8, MAX_N=5).
module tb_alu_matrix_engine;
  typedef int vec_t[9];
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   opcode = '0;
  logic [3:0]   matrix_size = '0;
  logic [199:0] A_flat = '0, B_flat = '0;
  logic signed [7:0] scalar = '0;
  logic [199:0] C_flat;
  logic         busy, done, overflow_flag, error_flag;
  int errs = 0, chks = 0;

  alu_matrix_engine #(.ELEM_W(8), .MAX_N(5)) dut (
    .clock(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .matrix_size(matrix_size),
    .A_flat(A_flat), .B_flat(B_flat), .scalar(scalar), .C_flat(C_flat), .busy(busy), .done(done),
    .overflow_flag(overflow_flag), .error_flag(error_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [199:0] mk(input int n, input vec_t v);
    logic [199:0] r = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        r[(i*5+j)*8 +: 8] = 8'(v[i*n+j]);
    return r;
  endfunction

  // Returns in the done cycle (cycle index counted from the accept cycle 0), sampled at negedge.
  task automatic run(input logic [2:0] op, input int n, input logic [199:0] a, input logic [199:0] b,
                     input int s, output int cyc);
    @(negedge clk);
    opcode = op; matrix_size = 4'(n); A_flat = a; B_flat = b; scalar = 8'(s); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    #1;
    chks++;
    if ({C_flat, busy, done, overflow_flag, error_flag} !== '0) begin
      errs++; $display("FAIL reset_outputs got C=%h b=%b d=%b o=%b e=%b exp all 0", C_flat, busy, done, overflow_flag, error_flag);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_sum;
    int cyc;
    logic [199:0] exp;
    exp = mk(2, '{11, 22, 33, 44, 0, 0, 0, 0, 0});
    run(3'b001, 2, mk(2, '{1, 2, 3, 4, 0, 0, 0, 0, 0}), mk(2, '{10, 20, 30, 40, 0, 0, 0, 0, 0}), 0, cyc);
    chks++; if (cyc !== 5) begin errs++; $display("FAIL sum_done_cycle got=%0d exp=5", cyc); end
    chks++; if (C_flat !== exp) begin errs++; $display("FAIL sum_c got=%h exp=%h", C_flat, exp); end
    chks++; if (overflow_flag !== 1'b0 || error_flag !== 1'b0) begin errs++; $display("FAIL sum_flags got ovf=%b err=%b exp 0 0", overflow_flag, error_flag); end
    chks++; if (busy !== 1'b1) begin errs++; $display("FAIL sum_busy_done got=%b exp=1", busy); end
    @(negedge clk);
    chks++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL sum_idle got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_sub_scalar;
    int cyc;
    logic [199:0] exp;
    exp = mk(2, '{4, 4, 4, 4, 0, 0, 0, 0, 0});
    run(3'b010, 2, mk(2, '{5, 6, 7, 8, 0, 0, 0, 0, 0}), mk(2, '{1, 2, 3, 4, 0, 0, 0, 0, 0}), 0, cyc);
    chks++; if (C_flat !== exp) begin errs++; $display("FAIL sub_c got=%h exp=%h", C_flat, exp); end
    exp = mk(2, '{-3, 6, -9, -12, 0, 0, 0, 0, 0});
    run(3'b110, 2, mk(2, '{1, -2, 3, 4, 0, 0, 0, 0, 0}), '0, -3, cyc);
    chks++; if (C_flat !== exp || cyc !== 5) begin errs++; $display("FAIL scalar_c got=%h cyc=%0d exp=%h cyc=5", C_flat, cyc, exp); end
  endtask

  task automatic test_mul;
    int cyc;
    logic [199:0] exp;
    exp = mk(3, '{1, 2, 3, 4, 5, 6, 7, 8, 9});
    run(3'b011, 3, mk(3, '{1, 0, 0, 0, 1, 0, 0, 0, 1}), {200{1'b1}} & exp | 200'(1) << 199, 0, cyc);
    chks++; if (cyc !== 28) begin errs++; $display("FAIL mul_identity_cycle got=%0d exp=28", cyc); end
    chks++; if (C_flat !== exp) begin errs++; $display("FAIL mul_identity_c got=%h exp=%h", C_flat, exp); end
    exp = mk(2, '{19, 22, 43, 50, 0, 0, 0, 0, 0});
    run(3'b011, 2, mk(2, '{1, 2, 3, 4, 0, 0, 0, 0, 0}), mk(2, '{5, 6, 7, 8, 0, 0, 0, 0, 0}), 0, cyc);
    chks++; if (C_flat !== exp || cyc !== 9) begin errs++; $display("FAIL mul_2x2 got=%h cyc=%0d exp=%h cyc=9", C_flat, cyc, exp); end
    // intermediate sum 200 overflows 8 bits but the final 100 does not
    exp = mk(3, '{100, 100, 100, 0, 0, 0, 0, 0, 0});
    run(3'b011, 3, mk(3, '{100, 100, -100, 0, 0, 0, 0, 0, 0}), mk(3, '{1, 1, 1, 1, 1, 1, 1, 1, 1}), 0, cyc);
    chks++; if (C_flat !== exp || overflow_flag !== 1'b0) begin errs++; $display("FAIL mul_partial_ovf got=%h ovf=%b exp=%h ovf=0", C_flat, overflow_flag, exp); end
  endtask

  task automatic test_overflow;
    int cyc;
    logic [7:0] e_sum, e_opp;
`ifdef ALU_MATRIX_SATURATE_EN
    e_sum = 8'd127; e_opp = 8'd127;
`else
    e_sum = 8'hC8; e_opp = 8'h80;
`endif
    run(3'b001, 1, mk(1, '{100, 0, 0, 0, 0, 0, 0, 0, 0}), mk(1, '{100, 0, 0, 0, 0, 0, 0, 0, 0}), 0, cyc);
    chks++; if (overflow_flag !== 1'b1 || C_flat[7:0] !== e_sum || cyc !== 2) begin errs++; $display("FAIL sum_ovf got ovf=%b c=%h cyc=%0d exp ovf=1 c=%h cyc=2", overflow_flag, C_flat[7:0], cyc, e_sum); end
    run(3'b100, 1, mk(1, '{-128, 0, 0, 0, 0, 0, 0, 0, 0}), '0, 0, cyc);
    chks++; if (overflow_flag !== 1'b1 || C_flat[7:0] !== e_opp) begin errs++; $display("FAIL opp_ovf got ovf=%b c=%h exp ovf=1 c=%h", overflow_flag, C_flat[7:0], e_opp); end
    run(3'b100, 2, mk(2, '{1, -2, 3, 0, 0, 0, 0, 0, 0}), '0, 0, cyc);
    chks++; if (overflow_flag !== 1'b0 || C_flat !== mk(2, '{-1, 2, -3, 0, 0, 0, 0, 0, 0})) begin errs++; $display("FAIL opp_clear got ovf=%b c=%h exp ovf=0", overflow_flag, C_flat); end
  endtask

  task automatic test_transpose_hold;
    int cyc;
    logic [199:0] exp;
    exp = mk(2, '{1, 3, 2, 4, 0, 0, 0, 0, 0});
    run(3'b101, 2, mk(2, '{1, 2, 3, 4, 0, 0, 0, 0, 0}), '0, 0, cyc);
    chks++; if (C_flat !== exp || cyc !== 5) begin errs++; $display("FAIL transpose got=%h cyc=%0d exp=%h cyc=5", C_flat, cyc, exp); end
    A_flat = '1; B_flat = '1; opcode = 3'b001;
    repeat (3) @(negedge clk);
    chks++; if (C_flat !== exp || busy !== 1'b0) begin errs++; $display("FAIL hold got=%h busy=%b exp=%h busy=0", C_flat, busy, exp); end
  endtask

  task automatic test_error;
    int cyc;
    run(3'b111, 2, mk(2, '{1, 2, 3, 4, 0, 0, 0, 0, 0}), mk(2, '{1, 2, 3, 4, 0, 0, 0, 0, 0}), 0, cyc);
    chks++; if (error_flag !== 1'b1 || cyc !== 1 || C_flat !== '0 || busy !== 1'b1) begin errs++; $display("FAIL err_opcode got err=%b cyc=%0d busy=%b c=%h exp err=1 cyc=1 busy=1 c=0", error_flag, cyc, busy, C_flat); end
    run(3'b001, 6, '1, '1, 0, cyc);
    chks++; if (error_flag !== 1'b1 || cyc !== 1 || C_flat !== '0) begin errs++; $display("FAIL err_size got err=%b cyc=%0d c=%h exp err=1 cyc=1 c=0", error_flag, cyc, C_flat); end
    run(3'b001, 0, '1, '1, 0, cyc);
    chks++; if (error_flag !== 1'b1 || cyc !== 1) begin errs++; $display("FAIL err_zero got err=%b cyc=%0d exp err=1 cyc=1", error_flag, cyc); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [199:0] exp;
    exp = mk(2, '{19, 22, 43, 50, 0, 0, 0, 0, 0});
    @(negedge clk);
    opcode = 3'b011; matrix_size = 4'd2; start = 1'b1;
    A_flat = mk(2, '{1, 2, 3, 4, 0, 0, 0, 0, 0}); B_flat = mk(2, '{5, 6, 7, 8, 0, 0, 0, 0, 0});
    @(negedge clk);
    start = 1'b0; cyc = 1;
    @(negedge clk);
    cyc++;
    opcode = 3'b001; matrix_size = 4'd3; A_flat = '1; B_flat = '1; start = 1'b1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chks++; if (C_flat !== exp || cyc !== 9) begin errs++; $display("FAIL start_ignored got=%h cyc=%0d exp=%h cyc=9", C_flat, cyc, exp); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    @(negedge clk);
    opcode = 3'b011; matrix_size = 4'd3; start = 1'b1;
    A_flat = mk(3, '{1, 0, 0, 0, 1, 0, 0, 0, 1}); B_flat = mk(3, '{1, 2, 3, 4, 5, 6, 7, 8, 9});
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chks++; if (busy !== 1'b1 || C_flat === '0) begin errs++; $display("FAIL mid_running got busy=%b c=%h exp busy=1 c!=0", busy, C_flat); end
    #2 reset_n = 1'b0;
    #1;
    chks++; if ({C_flat, busy, done, overflow_flag, error_flag} !== '0) begin errs++; $display("FAIL mid_reset got C=%h b=%b d=%b o=%b e=%b exp all 0", C_flat, busy, done, overflow_flag, error_flag); end
    @(negedge clk);
    reset_n = 1'b1;
    run(3'b001, 2, mk(2, '{1, 2, 3, 4, 0, 0, 0, 0, 0}), mk(2, '{1, 1, 1, 1, 0, 0, 0, 0, 0}), 0, cyc);
    chks++; if (C_flat !== mk(2, '{2, 3, 4, 5, 0, 0, 0, 0, 0}) || cyc !== 5) begin errs++; $display("FAIL after_reset got=%h cyc=%0d exp sum cyc=5", C_flat, cyc); end
  endtask

  initial begin
    test_reset;
    test_sum;
    test_sub_scalar;
    test_mul;
    test_overflow;
    test_transpose_hold;
    test_error;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
